// File: rtl/spi_accel_reader.sv
// ADXL345 3-wire SPI front end: post-reset register init, then INT2-triggered burst reads of
// 1..3 axes with optional 2^AVG_LOG2 box-car averaging and a one-cycle oVALID strobe.
module spi_accel_reader #(
    parameter int         CLK_DIV     = 13,
    parameter int         NUM_AXES    = 3,
    parameter int         AVG_LOG2    = 0,
    parameter logic [7:0] INIT_FORMAT = 8'h40,
    parameter logic [7:0] INIT_RATE   = 8'h0A
) (
    input  logic                   iCLK,
    input  logic                   iRSTN,
    input  logic                   iG_INT2,
    output logic [16*NUM_AXES-1:0] oDATA,
    output logic                   oVALID,
    output logic                   oINIT_DONE,
    output logic                   oBUSY,
    inout  wire                    SPI_SDIO,
    output logic                   oSPI_CSN,
    output logic                   oSPI_CLK
);
    localparam int DATA_W  = 16 * NUM_AXES;
    localparam int RD_BITS = 8 + DATA_W;
    localparam int EDGE_W  = $clog2(2 * RD_BITS + 1);
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int GAP_W   = $clog2(2 * CLK_DIV + 1);
    localparam int ACC_W   = 16 + AVG_LOG2;
    localparam int CNT_W   = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);

    localparam logic [2:0] ST_WAIT = 3'd0;
    localparam logic [2:0] ST_INIT = 3'd1;
    localparam logic [2:0] ST_IDLE = 3'd2;
    localparam logic [2:0] ST_XFER = 3'd3;
    localparam logic [2:0] ST_ACC  = 3'd4;
    localparam logic [2:0] ST_OUT  = 3'd5;

    logic [2:0]              r_state;
    logic [9:0]              r_wait;
    logic [2:0]              r_init_idx;
    logic                    r_init_done;
    logic                    r_sync1, r_sync2;
    logic [DIV_W-1:0]        r_div;
    logic [EDGE_W-1:0]       r_edge, r_last;
    logic                    r_rd;
    logic [RD_BITS-1:0]      r_tx;
    logic [DATA_W-1:0]       r_rx;
    logic                    r_csn, r_sclk, r_sdo, r_sdio_oe;
    logic [GAP_W-1:0]        r_gap;
    logic signed [ACC_W-1:0] r_acc [NUM_AXES];
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_W-1:0]       r_data;
    logic                    r_valid;

    logic                    w_tick, w_start, w_start_rd;
    logic signed [15:0]      w_sample [NUM_AXES];

    function automatic logic [15:0] init_word(input logic [2:0] idx);
        case (idx)
            3'd0:    init_word = {2'b00, 6'h31, INIT_FORMAT};
            3'd1:    init_word = {2'b00, 6'h2C, INIT_RATE};
            3'd2:    init_word = {2'b00, 6'h2F, 8'h80};
            3'd3:    init_word = {2'b00, 6'h2E, 8'h80};
            default: init_word = {2'b00, 6'h2D, 8'h08};
        endcase
    endfunction

    assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_start_rd = (r_state == ST_IDLE);
    assign w_start    = (r_gap == '0) &&
                        ((r_state == ST_INIT) || (r_state == ST_IDLE && r_sync2));

    // Bursts arrive low byte first per axis; the first received byte sits at the top of r_rx.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        for (int k = 0; k < NUM_AXES; k++) begin
            w_sample[k] = {r_rx[DATA_W-9-16*k -: 8], r_rx[DATA_W-1-16*k -: 8]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            r_state     <= ST_WAIT;
            r_wait      <= '0;
            r_init_idx  <= '0;
            r_init_done <= 1'b0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_div       <= '0;
            r_edge      <= '0;
            r_last      <= '0;
            r_rd        <= 1'b0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_csn       <= 1'b1;
            r_sclk      <= 1'b1;
            r_sdo       <= 1'b0;
            r_sdio_oe   <= 1'b0;
            r_gap       <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            // NOTE: the accumulators are a handful of flops, not a RAM, so they are reset like any register.
            for (int k = 0; k < NUM_AXES; k++) r_acc[k] <= '0;
        end else begin
            r_sync1 <= iG_INT2;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            if (r_gap != '0) r_gap <= r_gap - 1'b1;

            case (r_state)
                ST_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    if (r_wait == 10'd1023) r_state <= ST_INIT;
                end
                ST_INIT, ST_IDLE: begin
                    if (w_start) begin
                        r_csn     <= 1'b0;
                        r_sdio_oe <= 1'b1;
                        r_sdo     <= w_start_rd;
                        r_div     <= '0;
                        r_edge    <= '0;
                        r_rd      <= w_start_rd;
                        r_last    <= w_start_rd ? EDGE_W'(2 * RD_BITS) : EDGE_W'(32);
                        r_tx      <= w_start_rd ? {8'hF2, {DATA_W{1'b0}}}
                                                : {init_word(r_init_idx), {(RD_BITS-16){1'b0}}};
                        r_state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        r_edge <= r_edge + 1'b1;
                        if (r_edge == r_last) begin
                            r_csn     <= 1'b1;
                            r_sdio_oe <= 1'b0;
                            r_gap     <= GAP_W'(2 * CLK_DIV);
                            if (r_rd) begin
                                r_state <= ST_ACC;
                            end else if (r_init_idx == 3'd4) begin
                                r_init_done <= 1'b1;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_init_idx <= r_init_idx + 1'b1;
                                r_state    <= ST_INIT;
                            end
                        end else if (!r_edge[0]) begin
                            r_sclk <= 1'b0;
                            r_sdo  <= r_tx[RD_BITS-1];
                            r_tx   <= {r_tx[RD_BITS-2:0], 1'b0};
                            // Hand the line to the sensor on the falling edge after command bit 0.
                            if (r_rd && r_edge == EDGE_W'(16)) r_sdio_oe <= 1'b0;
                        end else begin
                            r_sclk <= 1'b1;
                            if (r_rd && r_edge > EDGE_W'(16)) r_rx <= {r_rx[DATA_W-2:0], SPI_SDIO};
                        end
                    end
                end
                ST_ACC: begin
                    for (int k = 0; k < NUM_AXES; k++) r_acc[k] <= r_acc[k] + ACC_W'(w_sample[k]);
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    if (r_cnt == CNT_FULL) begin
                        // Dropping the low AVG_LOG2 bits is an arithmetic shift (floor) of the sum.
                        for (int k = 0; k < NUM_AXES; k++) begin
                            r_data[16*k +: 16] <= r_acc[k][AVG_LOG2 +: 16];
                            r_acc[k]           <= '0;
                        end
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    assign SPI_SDIO   = r_sdio_oe ? r_sdo : 1'bz;
    assign oSPI_CSN   = r_csn;
    assign oSPI_CLK   = r_sclk;
    assign oBUSY      = ~r_csn;
    assign oDATA      = r_data;
    assign oVALID     = r_valid;
    assign oINIT_DONE = r_init_done;

endmodule

// File: tb/tb_spi_accel_reader.sv
// Bench for spi_accel_reader: polled SPI slave model, init decode, burst reads, averaging table,
// back-to-back INT2, and asynchronous reset in the middle of a burst.
`timescale 1ns/1ps
module tb_spi_accel_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  int2, s_en, s_bit;
    wire  [2:0]  csn, sclk, valid, init_done, busy;
    wire  [47:0] data0;
    wire  [15:0] data1, data2;
    wire         sdio0, sdio1, sdio2;
    wire  [2:0]  sdio_v;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] init_exp [5] = '{16'h3140, 16'h2C0A, 16'h2F80, 16'h2E80, 16'h2D08};

    typedef struct {
        int          dut;
        logic [15:0] x;
        bit          ev;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [16];

    always #10 clk = ~clk;

    assign sdio0  = s_en[0] ? s_bit[0] : 1'bz;
    assign sdio1  = s_en[1] ? s_bit[1] : 1'bz;
    assign sdio2  = s_en[2] ? s_bit[2] : 1'bz;
    assign sdio_v = {sdio2, sdio1, sdio0};

    spi_accel_reader u_dut0 (
        .iCLK(clk), .iRSTN(rst_n), .iG_INT2(int2[0]), .oDATA(data0), .oVALID(valid[0]),
        .oINIT_DONE(init_done[0]), .oBUSY(busy[0]), .SPI_SDIO(sdio0), .oSPI_CSN(csn[0]),
        .oSPI_CLK(sclk[0]));

    spi_accel_reader #(.CLK_DIV(4), .NUM_AXES(1), .AVG_LOG2(2)) u_dut1 (
        .iCLK(clk), .iRSTN(rst_n), .iG_INT2(int2[1]), .oDATA(data1), .oVALID(valid[1]),
        .oINIT_DONE(init_done[1]), .oBUSY(busy[1]), .SPI_SDIO(sdio1), .oSPI_CSN(csn[1]),
        .oSPI_CLK(sclk[1]));

    spi_accel_reader #(.CLK_DIV(4), .NUM_AXES(1), .AVG_LOG2(1)) u_dut2 (
        .iCLK(clk), .iRSTN(rst_n), .iG_INT2(int2[2]), .oDATA(data2), .oVALID(valid[2]),
        .oINIT_DONE(init_done[2]), .oBUSY(busy[2]), .SPI_SDIO(sdio2), .oSPI_CSN(csn[2]),
        .oSPI_CLK(sclk[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave for one frame: waits for CSN low, samples SDIO on SCLK rises, and for reads drives
    // rdata (left-aligned, MSB first) from the falling edge after the command byte.
    task automatic run_frame(input int idx, input bit is_read, input bit clr_int,
                             input logic [47:0] rdata, output int wcyc,
                             output logic [15:0] mosi16, output int nrise, output bit oe_rel);
        int   cyc = 0;
        int   nfall = 0;
        int   busy_bad = 0;
        logic prev, cur, oe;
        wcyc = 0; nrise = 0; mosi16 = '0; oe_rel = 1'b0;
        while (csn[idx] == 1'b1 && wcyc < 5000) begin
            @(negedge clk);
            wcyc++;
        end
        if (csn[idx] == 1'b1) check("csn_fall_timeout", 1'b1, 1'b0);
        if (clr_int) int2[idx] = 1'b0;
        prev = sclk[idx];
        while (csn[idx] == 1'b0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            cur = sclk[idx];
            if (busy[idx] != ~csn[idx]) busy_bad++;
            if (!prev && cur) begin
                if (nrise < 16) mosi16 = {mosi16[14:0], sdio_v[idx]};
                if (nrise == 8) begin
                    case (idx)
                        0:       oe = u_dut0.r_sdio_oe;
                        1:       oe = u_dut1.r_sdio_oe;
                        default: oe = u_dut2.r_sdio_oe;
                    endcase
                    oe_rel = !oe;
                end
                nrise++;
            end else if (prev && !cur) begin
                if (is_read && nfall >= 8 && nfall < 56) begin
                    s_en[idx]  = 1'b1;
                    s_bit[idx] = rdata[47 - (nfall - 8)];
                end
                nfall++;
            end
            prev = cur;
        end
        s_en[idx] = 1'b0;
        if (csn[idx] == 1'b0) check("frame_end_timeout", 1'b1, 1'b0);
        check("busy_tracks_csn", busy_bad, 0);
    endtask

    task automatic watch_valid(input int idx, output int vcnt, output int vpos);
        vcnt = 0; vpos = -1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (valid[idx]) begin
                vcnt++;
                if (vpos < 0) vpos = n;
            end
        end
    endtask

    task automatic run_init(input string tag, input bit raise_int);
        int          wcyc, nrise;
        logic [15:0] mosi;
        bit          rel;
        for (int f = 0; f < 5; f++) begin
            run_frame(0, 1'b0, 1'b0, 48'h0, wcyc, mosi, nrise, rel);
            if (f == 0) check({tag, "_wait_1024"}, (wcyc >= 1024 && wcyc <= 1026), 1'b1);
            check($sformatf("%s_word%0d", tag, f), mosi, init_exp[f]);
            check($sformatf("%s_bits%0d", tag, f), nrise, 16);
            check($sformatf("%s_done%0d", tag, f), init_done[0], (f == 4));
            if (raise_int && f == 1) int2[0] = 1'b1;
        end
    endtask

    initial begin
        int          wcyc, nrise, vcnt, vpos, cyc, nr;
        logic [15:0] mosi, act;
        bit          rel;
        logic        prev;

        vecs[0]  = '{1, 16'h0064, 1'b0, 16'h0000};
        vecs[1]  = '{1, 16'h0065, 1'b0, 16'h0000};
        vecs[2]  = '{1, 16'hFFFD, 1'b0, 16'h0000};
        vecs[3]  = '{1, 16'hFFFB, 1'b1, 16'h0030};
        vecs[4]  = '{2, 16'hFFFF, 1'b0, 16'h0000};
        vecs[5]  = '{2, 16'hFFFE, 1'b1, 16'hFFFE};
        vecs[6]  = '{2, 16'h7FFF, 1'b0, 16'hFFFE};
        vecs[7]  = '{2, 16'h7FFF, 1'b1, 16'h7FFF};
        vecs[8]  = '{2, 16'h8000, 1'b0, 16'h7FFF};
        vecs[9]  = '{2, 16'h8000, 1'b1, 16'h8000};
        vecs[10] = '{2, 16'h0003, 1'b0, 16'h8000};
        vecs[11] = '{2, 16'h0004, 1'b1, 16'h0003};
        vecs[12] = '{1, 16'h8000, 1'b0, 16'h0030};
        vecs[13] = '{1, 16'h8000, 1'b0, 16'h0030};
        vecs[14] = '{1, 16'h8000, 1'b0, 16'h0030};
        vecs[15] = '{1, 16'h8000, 1'b1, 16'h8000};

        rst_n = 1'b0; int2 = '0; s_en = '0; s_bit = '0;
        repeat (3) @(negedge clk);
        check("rst_csn", csn, 3'b111);
        check("rst_sclk", sclk, 3'b111);
        check("rst_valid", valid, 3'b000);
        check("rst_init_done", init_done, 3'b000);
        check("rst_busy", busy, 3'b000);
        check("rst_data0", data0, 48'h0);
        check("rst_sdio_oe", u_dut0.r_sdio_oe, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        run_init("init", 1'b1);

        // INT2 went high during init; the first burst follows oINIT_DONE.
        run_frame(0, 1'b1, 1'b1, 48'h3412_CDAB_0100, wcyc, mosi, nrise, rel);
        check("rd0_cmd", mosi[15:8], 8'hF2);
        check("rd0_bits", nrise, 56);
        check("rd0_sdio_released", rel, 1'b1);
        watch_valid(0, vcnt, vpos);
        check("rd0_valid_count", vcnt, 1);
        check("rd0_valid_pos", vpos, 2);
        check("rd0_data", data0, 48'h0001_ABCD_1234);

        repeat (40) @(negedge clk);
        int2[0] = 1'b1;
        run_frame(0, 1'b1, 1'b1, 48'hFF7F_0080_FEFF, wcyc, mosi, nrise, rel);
        check("rd1_int2_latency", (wcyc >= 1 && wcyc <= 3), 1'b1);
        watch_valid(0, vcnt, vpos);
        check("rd1_valid_count", vcnt, 1);
        check("rd1_data", data0, 48'hFFFE_8000_7FFF);

        cyc = 0;
        while (init_done[2:1] != 2'b11 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("avg_duts_init_done", init_done[2:1], 2'b11);

        for (int i = 0; i < 16; i++) begin
            repeat (20) @(negedge clk);
            int2[vecs[i].dut] = 1'b1;
            run_frame(vecs[i].dut, 1'b1, 1'b1, {vecs[i].x[7:0], vecs[i].x[15:8], 32'h0},
                      wcyc, mosi, nrise, rel);
            check($sformatf("vec%0d_cmd", i), mosi[15:8], 8'hF2);
            check($sformatf("vec%0d_bits", i), nrise, 24);
            watch_valid(vecs[i].dut, vcnt, vpos);
            check($sformatf("vec%0d_valid_count", i), vcnt, vecs[i].ev ? 1 : 0);
            if (vecs[i].ev) check($sformatf("vec%0d_valid_pos", i), vpos, 2);
            act = (vecs[i].dut == 1) ? data1 : data2;
            check($sformatf("vec%0d_data", i), act, vecs[i].exp);
        end

        // INT2 held high: two back-to-back bursts separated by at least two half-periods.
        repeat (20) @(negedge clk);
        int2[2] = 1'b1;
        run_frame(2, 1'b1, 1'b0, {8'h0A, 8'h00, 32'h0}, wcyc, mosi, nrise, rel);
        run_frame(2, 1'b1, 1'b1, {8'h14, 8'h00, 32'h0}, wcyc, mosi, nrise, rel);
        check("held_gap", (wcyc >= 8 && wcyc <= 20), 1'b1);
        check("held_cmd", mosi[15:8], 8'hF2);
        watch_valid(2, vcnt, vpos);
        check("held_valid_count", vcnt, 1);
        check("held_data", data2, 16'h000F);
        repeat (40) @(negedge clk);
        check("held_no_extra_burst", csn[2], 1'b1);

        // Asynchronous reset on the falling edge of bit 20 of a burst.
        int2[0] = 1'b1;
        cyc = 0;
        while (csn[0] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        int2[0] = 1'b0;
        nr = 0;
        prev = sclk[0];
        while (nr < 20 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!prev && sclk[0]) nr++;
            prev = sclk[0];
        end
        while (sclk[0] && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_reached_bit20", {nr == 20, sclk[0], csn[0]}, 3'b100);
        rst_n = 1'b0;
        #1;
        check("rst_mid_csn", csn[0], 1'b1);
        check("rst_mid_sclk", sclk[0], 1'b1);
        check("rst_mid_sdio_oe", u_dut0.r_sdio_oe, 1'b0);
        check("rst_mid_data0", data0, 48'h0);
        check("rst_mid_init_done", init_done[0], 1'b0);
        check("rst_mid_busy", busy[0], 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        run_init("reinit", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_accel_reader.md
# spi_accel_reader

Multi-axis, parametrised successor to the single-axis accelerometer config/readback block for the DE10-Lite ADXL345 G-sensor. Runs from the 50 MHz system clock with an internal SCLK divider; no dedicated SPI PLL is needed. After reset it writes a fixed five-register init sequence over 3-wire SPI. It then burst-reads 1–3 axes on every data-ready (INT2) assertion, optionally box-car averages 2^AVG_LOG2 samples, and presents them with a one-cycle valid strobe to downstream LED/VGA consumers.

## Interface
- CLK_DIV, 13, iCLK cycles per SCLK half-period (≥2); 13 gives ≈1.92 MHz at 50 MHz
- NUM_AXES, 3, axes per burst (1..3): X, then Y, then Z from register 0x32 upward
- AVG_LOG2, 0, samples averaged = 2^AVG_LOG2 (0..4)
- INIT_FORMAT, 8'h40, value written to DATA_FORMAT (0x31); 3-wire SPI, ±2 g
- INIT_RATE, 8'h0A, value written to BW_RATE (0x2C)
- iCLK  in  1  system clock, 50 MHz
- iRSTN  in  1  reset, asynchronous assert, active-low
- iG_INT2  in  1  sensor data-ready, asynchronous, active-high level
- oDATA  out  16*NUM_AXES  signed samples; axis 0 in [15:0]
- oVALID  out  1  one-cycle strobe when oDATA updates
- oINIT_DONE  out  1  high once init writes complete, stays high until reset
- oBUSY  out  1  high while oSPI_CSN is low
- SPI_SDIO  inout  1  3-wire bidirectional data
- oSPI_CSN  out  1  chip select, active-low
- oSPI_CLK  out  1  SCLK

## Operation
- Reset values: oSPI_CSN=1, oSPI_CLK=1, SPI_SDIO=Z, oDATA=0, oVALID=0, oINIT_DONE=0, oBUSY=0. Accumulators, counters and the synchroniser clear.
- SPI mode 3, MSB first: SCLK idles high, SDIO changes on the falling edge and is sampled on the rising edge.
- Write frame, 16 bits: {R/W=0, MB=0, addr[5:0], data[7:0]}.
- Read frame: {R/W=1, MB=1, 6'h32}, then 2*NUM_AXES bytes.
  - Block drives SDIO only during the 8 command bits and releases it (Z) from the falling edge after command bit 0.
  - Bytes arrive low byte first per axis.
- iG_INT2 passes through a 2-flop synchroniser before use.
- States:
  - WAIT: 1024 iCLK after reset release.
  - INIT: five writes in order: 0x31←INIT_FORMAT, 0x2C←INIT_RATE, 0x2F←0x80 (DATA_READY to INT2), 0x2E←0x80 (DATA_READY enable), 0x2D←0x08 (measure). On completion oINIT_DONE←1, go IDLE.
  - IDLE: if synced INT2=1, go READ. The trigger is level-sensitive; the sensor clears INT2 when data is read.
  - READ: one burst frame, then ACC.
  - ACC: add each sign-extended axis value to a (16+AVG_LOG2)-bit accumulator and increment the sample count.
    - If count=2^AVG_LOG2: oDATA[axis] ← accumulator >>> AVG_LOG2 (arithmetic, floor); pulse oVALID; clear accumulators and count.
    - In all cases, return to IDLE.
- AVG_LOG2=0: each burst updates oDATA directly; no arithmetic change.
- INT2 asserting during INIT or READ is ignored until IDLE. No sample is lost, because the level persists.

## Timing
- One bit = 2*CLK_DIV iCLK cycles.
- oSPI_CSN falls one half-period before the first SCLK falling edge. It rises one half-period after the last rising edge.
- CS high between frames: at least 2 half-periods.
- Write frame: 16 bits. Read frame: 8+16*NUM_AXES bits. NUM_AXES=3, CLK_DIV=13 gives 56 bits = 1456 cycles.
- oVALID asserts 2 iCLK cycles after oSPI_CSN rises on the completing burst. It lasts exactly 1 cycle.
- oDATA changes only on the oVALID cycle and holds otherwise.
- INT2 to CSN fall: ≤ 3 iCLK cycles plus one half-period.
- Reset mid-frame: all outputs take reset values immediately (asynchronously). Init restarts after the WAIT delay. The partial frame is discarded.

## Test plan
- Reset, then run with a slave model → after 1024 cycles, five 16-bit writes decode as 0x31/40, 0x2C/0A, 0x2F/80, 0x2E/80, 0x2D/08; then oINIT_DONE=1.
- NUM_AXES=3, AVG_LOG2=0: slave returns bytes 34 12 CD AB 01 00 on INT2 → oDATA={16'h0001,16'hABCD,16'h1234} with one oVALID pulse. The read command byte observed is 0xF2, and SDIO is Z after the command.
- AVG_LOG2=2: four bursts with axis0 = 100, 101, −3, −5 → a single oVALID after the 4th burst, with oDATA[15:0]=16'sd48 (193>>>2). No oVALID after bursts 1–3.
- AVG_LOG2=1: axis0 = −1, −2 → −2 (floor of −1.5).
- INT2 held high continuously → back-to-back bursts with CS high gap ≥ 2*CLK_DIV cycles. INT2 pulsed during INIT → first burst starts only after oINIT_DONE.
- Assert iRSTN low mid-burst (bit 20) → CSN=1, SCLK=1, SDIO=Z, oDATA=0 the same cycle; a full init is re-sent after release.
